cmd_issue_queue: RTL and testbench
==================================

// Module: cmd_issue_queue
// PURPOSE
//  Stage directly upstream of the LLC cache. Buffers trace commands (command_t: n[3:0], address[31:0], 5 reserved bits),
//  decodes n, issues cache ops (n=0..6) over a valid/ready handshake and converts control codes
//  (n=8 clear, n=9 print) into one-cycle pulses. Codes 7 and 10..15 are dropped and flagged.
// PARAMETERS
//  DEPTH   8   queue entries; power of two, >=2
//  CMD_W   41  command width: {n[40:37], address[36:5], rsvd[4:0]}
// PORTS
//  clk          in   1               clock, rising edge
//  rst_n        in   1               async reset, active low
//  in_valid     in   1               upstream command valid
//  in_ready     out  1               queue can accept; = !full
//  in_cmd       in   CMD_W           upstream command
//  out_valid    out  1               cache op at head is presented
//  out_ready    in   1               cache accepts out_cmd
//  out_cmd      out  CMD_W           head command, unmodified
//  clear_req    out  1               1-cycle pulse: n=8 reached head
//  print_req    out  1               1-cycle pulse: n=9 reached head
//  illegal_cmd  out  1               1-cycle pulse: n=7 or n>=10 reached head
//  level        out  $clog2(DEPTH)+1 entries held (0..DEPTH)
//  issued_cnt   out  32              cache ops accepted (STATS_EN)
//  dropped_cnt  out  32              illegal commands dropped (STATS_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): queue emptied, level=0, state S_IDLE, in_ready=1, out_valid=0,
//    out_cmd=0, all pulses 0, counters 0. Reset mid-operation discards every queued/presented command.
//  - Push on in_valid&&in_ready at posedge. Full: in_ready=0 even if a pop occurs that cycle (no pass-through).
//  - Push and pop in the same cycle: level unchanged. Pointers wrap modulo DEPTH.
//  - FSM, registered, evaluates head each posedge:
//     S_IDLE : queue empty. Non-empty -> S_ISSUE if head n<=6, else S_CTRL.
//     S_ISSUE: out_valid=1, out_cmd=head. On out_valid&&out_ready pop; next head decoded same edge
//              -> S_ISSUE / S_CTRL / S_IDLE (back-to-back issue, 1 op per cycle).
//     S_CTRL : exactly one of clear_req/print_req/illegal_cmd high for this cycle; head popped at
//              end of cycle; next state from new head as above.
//  - Latency: command pushed into empty queue at edge T -> out_valid (or pulse) high after edge T+1.
//  - out_cmd stable and out_valid held while out_ready=0; withdrawal not allowed.
//  - Pulses never overlap out_valid; strict in-order processing, so n=8 pulses only after all
//    earlier ops were accepted by the cache.
//  - out_cmd=0 whenever out_valid=0.
//  - Counters wrap at 2^32. issued_cnt +1 per out handshake; dropped_cnt +1 per illegal_cmd pulse.
// CONFIGURATION
//  CMD_ISSUE_STATS_EN defined: issued_cnt/dropped_cnt counters built as above.
//  Not defined: counter logic removed; ports retained, tied to 32'h0.
// TESTING
//  1 Reset then push n=0 addr 32'h1234_5678 at edge T, out_ready=1 -> out_valid after T+1,
//    out_cmd={4'h0,32'h1234_5678,5'h0}, level back to 0 after T+2.
//  2 out_ready=0, push 8 cmds -> level=8, in_ready=0, 9th in_valid ignored; release out_ready ->
//    8 ops issued on 8 consecutive cycles in push order.
//  3 Sequence n=1, n=8, n=2 with out_ready=1 -> op n=1, then clear_req 1 cycle, then op n=2;
//    clear_req never coincident with out_valid.
//  4 Push n=7, n=9, n=15 -> illegal_cmd, print_req, illegal_cmd pulses; out_valid stays 0;
//    dropped_cnt=2 (STATS_EN) or 0 (without).
//  5 Queue level 3, out_ready=0, assert rst_n=0 mid-cycle -> out_valid=0, level=0 immediately;
//    after release, no stale command issued.
//  6 Level 4, simultaneous push and pop for 10 cycles -> level stays 4, order preserved across
//    pointer wrap; issued_cnt=10.

Source files
------------

// File: rtl/cmd_issue_queue.sv
// Command issue queue ahead of the LLC: buffers trace commands, issues cache ops over valid/ready
// and turns control codes into pulses. Define CMD_ISSUE_STATS_EN to build the issue/drop counters.
module cmd_issue_queue #(
    parameter int DEPTH = 8,
    parameter int CMD_W = 41
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CMD_W-1:0]         in_cmd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CMD_W-1:0]         out_cmd,
    output logic                     clear_req,
    output logic                     print_req,
    output logic                     illegal_cmd,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              issued_cnt,
    output logic [31:0]              dropped_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CTRL} state_t;

    state_t             state_q;
    logic [CMD_W-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      count_q, count_d;
    logic               out_valid_q;
    logic [CMD_W-1:0]   out_cmd_q;
    logic               clear_q, print_q, illegal_q;

    logic               push, pop, has_next;
    logic [AW-1:0]      rd_ptr_inc;
    logic [CMD_W-1:0]   next_head;
    logic [3:0]         next_n;

    // Full blocks pushes even when the head leaves in the same cycle.
    assign in_ready   = (count_q != LW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = ((state_q == S_ISSUE) && out_ready) || (state_q == S_CTRL);
    assign rd_ptr_inc = rd_ptr_q + AW'(1);

    // The head for the next cycle comes only from already-stored entries.
    assign has_next  = pop ? (count_q > LW'(1)) : (count_q != '0);
    assign next_head = pop ? mem_q[rd_ptr_inc] : mem_q[rd_ptr_q];
    assign next_n    = next_head[CMD_W-1 -: 4];

    assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_inc        : rd_ptr_q;
    assign count_d  = count_q + LW'(push) - LW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_cmd_q   <= '0;
            clear_q     <= 1'b0;
            print_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_cmd_q   <= '0;
            clear_q     <= 1'b0;
            print_q     <= 1'b0;
            illegal_q   <= 1'b0;
            if (!has_next) begin
                state_q <= S_IDLE;
            end else if (next_n <= 4'd6) begin
                state_q     <= S_ISSUE;
                out_valid_q <= 1'b1;
                out_cmd_q   <= next_head;
            end else begin
                state_q   <= S_CTRL;
                clear_q   <= (next_n == 4'd8);
                print_q   <= (next_n == 4'd9);
                illegal_q <= (next_n != 4'd8) && (next_n != 4'd9);
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_cmd     = out_cmd_q;
    assign clear_req   = clear_q;
    assign print_req   = print_q;
    assign illegal_cmd = illegal_q;
    assign level       = count_q;

`ifdef CMD_ISSUE_STATS_EN
    logic [31:0] issued_q, dropped_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q  <= '0;
            dropped_q <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                issued_q <= issued_q + 32'd1;
            end
            if (illegal_q) begin
                dropped_q <= dropped_q + 32'd1;
            end
        end
    end

    assign issued_cnt  = issued_q;
    assign dropped_cnt = dropped_q;
`else
    assign issued_cnt  = 32'h0;
    assign dropped_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_cmd_issue_queue.sv
// Bench for cmd_issue_queue: directed steps plus random traffic against a queue-based reference model.
module tb_cmd_issue_queue;

    localparam int DEPTH = 8;
    localparam int CMD_W = 41;
`ifdef CMD_ISSUE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef enum int {K_NONE, K_OP, K_CLR, K_PRT, K_ILL} kind_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CMD_W-1:0] in_cmd = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CMD_W-1:0] out_cmd;
    logic             clear_req, print_req, illegal_cmd;
    logic [3:0]       level;
    logic [31:0]      issued_cnt, dropped_cnt;

    int errors = 0;
    int checks = 0;

    logic [CMD_W-1:0] m_q [$];
    kind_t            m_kind = K_NONE;
    logic [CMD_W-1:0] m_head = '0;
    int unsigned      m_issued = 0;
    int unsigned      m_dropped = 0;

    cmd_issue_queue #(.DEPTH(DEPTH), .CMD_W(CMD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
        .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
        .clear_req(clear_req), .print_req(print_req), .illegal_cmd(illegal_cmd),
        .level(level), .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CMD_W-1:0] mk(input logic [3:0] n, input logic [31:0] a, input logic [4:0] r);
        return {n, a, r};
    endfunction

    function automatic kind_t classify(input logic [CMD_W-1:0] c);
        logic [3:0] n;
        n = c[CMD_W-1 -: 4];
        if (n <= 4'd6) return K_OP;
        if (n == 4'd8) return K_CLR;
        if (n == 4'd9) return K_PRT;
        return K_ILL;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", 64'(in_ready), 64'(m_q.size() < DEPTH));
        chk("out_valid", 64'(out_valid), 64'(m_kind == K_OP));
        chk("out_cmd", 64'(out_cmd), (m_kind == K_OP) ? 64'(m_head) : 64'h0);
        chk("clear_req", 64'(clear_req), 64'(m_kind == K_CLR));
        chk("print_req", 64'(print_req), 64'(m_kind == K_PRT));
        chk("illegal_cmd", 64'(illegal_cmd), 64'(m_kind == K_ILL));
        chk("pulse_overlap", 64'(out_valid && (clear_req || print_req || illegal_cmd)), 64'h0);
        chk("level", 64'(level), 64'(m_q.size()));
        chk("issued_cnt", 64'(issued_cnt), STATS ? 64'(m_issued) : 64'h0);
        chk("dropped_cnt", 64'(dropped_cnt), STATS ? 64'(m_dropped) : 64'h0);
    endtask

    // Called at a negedge; drives inputs, advances one clock, updates the model, checks at the next negedge.
    task automatic step(input logic v, input logic [CMD_W-1:0] c, input logic r);
        bit full_pre, pop_now;
        in_valid  = v;
        in_cmd    = c;
        out_ready = r;
        @(posedge clk);
        full_pre = (m_q.size() >= DEPTH);
        pop_now  = (m_kind == K_OP && r) || (m_kind == K_CLR) || (m_kind == K_PRT) || (m_kind == K_ILL);
        if (m_kind == K_OP && r) m_issued++;
        if (m_kind == K_ILL) m_dropped++;
        if (pop_now) void'(m_q.pop_front());
        if (m_q.size() > 0) begin
            m_kind = classify(m_q[0]);
            m_head = m_q[0];
        end else begin
            m_kind = K_NONE;
        end
        if (v && !full_pre) m_q.push_back(c);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic r, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, r);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        m_q.delete();
        m_kind    = K_NONE;
        m_issued  = 0;
        m_dropped = 0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single op: visible one edge after the push, gone one edge later.
        step(1'b1, mk(4'h0, 32'h1234_5678, 5'h0), 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t1_out_valid", 64'(out_valid), 64'h1);
        chk("t1_out_cmd", 64'(out_cmd), 64'(mk(4'h0, 32'h1234_5678, 5'h0)));
        step(1'b0, '0, 1'b1);
        chk("t1_level", 64'(level), 64'h0);

        // Fill while stalled, try a ninth push, then drain.
        for (int i = 0; i < 8; i++) step(1'b1, mk(4'(i % 7), 32'hA000_0000 + 32'(i), 5'(i)), 1'b0);
        chk("t2_level_full", 64'(level), 64'h8);
        chk("t2_in_ready", 64'(in_ready), 64'h0);
        step(1'b1, mk(4'h3, 32'hDEAD_BEEF, 5'h1F), 1'b0);
        chk("t2_level_after_9th", 64'(level), 64'h8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain_valid", 64'(out_valid), 64'h1);
            chk("t2_drain_addr", 64'(out_cmd[36:5]), 64'(32'hA000_0000 + 32'(i)));
            step(1'b0, '0, 1'b1);
        end
        idle(1'b1, 2);

        // Op, clear, op in order.
        step(1'b1, mk(4'h1, 32'h0000_0100, 5'h0), 1'b1);
        step(1'b1, mk(4'h8, 32'h0000_0200, 5'h0), 1'b1);
        step(1'b1, mk(4'h2, 32'h0000_0300, 5'h0), 1'b1);
        idle(1'b1, 4);

        // Control and illegal codes only.
        do_reset();
        step(1'b1, mk(4'h7, 32'h1, 5'h0), 1'b1);
        step(1'b1, mk(4'h9, 32'h2, 5'h0), 1'b1);
        step(1'b1, mk(4'hF, 32'h3, 5'h0), 1'b1);
        idle(1'b1, 4);
        chk("t4_dropped", 64'(dropped_cnt), STATS ? 64'h2 : 64'h0);

        // Reset mid-cycle with three entries held.
        for (int i = 0; i < 3; i++) step(1'b1, mk(4'h4, 32'hB000_0000 + 32'(i), 5'h0), 1'b0);
        #2;
        do_reset();
        chk("t5_level", 64'(level), 64'h0);
        idle(1'b1, 4);

        // Steady push/pop at level 4 across the pointer wrap.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, mk(4'h5, 32'hC000_0000 + 32'(i), 5'h0), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, mk(4'h6, 32'hC100_0000 + 32'(i), 5'h0), 1'b1);
        chk("t6_level", 64'(level), 64'h4);
        chk("t6_issued", 64'(issued_cnt), STATS ? 64'd10 : 64'h0);
        idle(1'b1, 6);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] n;
            n = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(7, 15));
            step(1'($urandom_range(0, 1)), mk(n, $urandom(), 5'($urandom_range(0, 31))),
                 ($urandom_range(0, 2) != 0));
        end
        idle(1'b1, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
